// File: rtl/encoder_pkg.sv
// Shared types and constants for the 4-to-2 priority encoder slice.
// Holds the index encoding and a population-count helper used for multi-hot detection.
package encoder_pkg;

    localparam int IN_W  = 4;
    localparam int OUT_W = 2;

    typedef logic [OUT_W-1:0] enc_idx_t;

    localparam enc_idx_t IDX0 = 2'd0;
    localparam enc_idx_t IDX1 = 2'd1;
    localparam enc_idx_t IDX2 = 2'd2;
    localparam enc_idx_t IDX3 = 2'd3;

    // Bundled result so the top can register all three outputs as one word.
    typedef struct packed {
        enc_idx_t idx;
        logic     any_set;
        logic     multi_set;
    } enc_res_t;

    function automatic logic [2:0] popcount4(input logic [IN_W-1:0] v);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < IN_W; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/encoder_4to2_core.sv
// Combinational priority encode of a 4-bit request vector: highest set bit wins.
// Zero latency, no flow control; also reports any-set and two-or-more-set flags.
module encoder_4to2_core
    import encoder_pkg::*;
(
    input  logic [IN_W-1:0] req_i,
    output enc_idx_t        idx_o,
    output logic            any_set_o,
    output logic            multi_set_o
);

    always_comb begin
        idx_o = IDX0;
        if (req_i[3]) begin
            idx_o = IDX3;
        end else if (req_i[2]) begin
            idx_o = IDX2;
        end else if (req_i[1]) begin
            idx_o = IDX1;
        end else begin
            // in[0] alone and all-zero share index 0; any_set disambiguates.
            idx_o = IDX0;
        end
    end

    assign any_set_o   = |req_i;
    assign multi_set_o = (popcount4(req_i) >= 3'd2);

endmodule

// File: rtl/encoder_4to2.sv
// Registered 4-to-2 priority encoder with valid/multi flags; async active-high reset.
// Latency 1 cycle, one result per cycle, no backpressure; outputs driven only from flops.
module encoder_4to2
    import encoder_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] in,
    output logic [OUT_W-1:0] out,
    output logic            valid,
    output logic            multi
);

    enc_res_t res_d;
    enc_res_t res_q;

    encoder_4to2_core u_core (
        .req_i       (in),
        .idx_o       (res_d.idx),
        .any_set_o   (res_d.any_set),
        .multi_set_o (res_d.multi_set)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign out   = res_q.idx;
    assign valid = res_q.any_set;
    assign multi = res_q.multi_set;

endmodule

// File: tb/tb_encoder_4to2.sv
// Scoreboard bench for encoder_4to2: expectations queued at drive time, popped one edge later.
module tb_encoder_4to2;

    typedef struct packed {
        logic [1:0] o;
        logic       v;
        logic       m;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic [1:0] dout;
    logic       dvalid;
    logic       dmulti;

    exp_t sb[$];
    int   compared;
    int   mismatched;

    encoder_4to2 dut (
        .clk   (clk),
        .rst   (rst),
        .in    (din),
        .out   (dout),
        .valid (dvalid),
        .multi (dmulti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: scan for highest set bit, count ones.
    function automatic exp_t model(input logic [3:0] v);
        exp_t e;
        int   ones;
        e    = '0;
        ones = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                e.o  = 2'(i);
                ones = ones + 1;
            end
        end
        e.v = (ones > 0);
        e.m = (ones > 1);
        return e;
    endfunction

    // Drive one input, queue its expectation, advance to just after the capturing edge.
    task automatic apply(input logic [3:0] v, input exp_t e);
        din = v;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t got;
        rst = 1'b0;
        din = 4'b1111;
        #3;
        rst = 1'b1;
        #1;
        got = {dout, dvalid, dmulti};
        compared++;
        if (got !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_initial got out=%b valid=%b multi=%b want 00/0/0", dout, dvalid, dmulti);
        end
        repeat (2) @(posedge clk);
        #1;
        got = {dout, dvalid, dmulti};
        compared++;
        if (got !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_hold got out=%b valid=%b multi=%b want 00/0/0", dout, dvalid, dmulti);
        end
        #2;
        rst = 1'b0;
    endtask

    task automatic test_one_hot();
        logic [3:0] ins  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [1:0] outs [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        exp_t e;
        exp_t got;
        for (int i = 0; i < 4; i++) begin
            apply(ins[i], '{outs[i], 1'b1, 1'b0});
            e   = sb.pop_front();
            got = {dout, dvalid, dmulti};
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL one_hot in=%b got %b/%b/%b want %b/%b/%b",
                         ins[i], dout, dvalid, dmulti, e.o, e.v, e.m);
            end
        end
    endtask

    task automatic test_multi_hot();
        logic [3:0] ins  [4] = '{4'b0011, 4'b1111, 4'b0110, 4'b0101};
        logic [1:0] outs [4] = '{2'b01, 2'b11, 2'b10, 2'b10};
        exp_t e;
        exp_t got;
        for (int i = 0; i < 4; i++) begin
            apply(ins[i], '{outs[i], 1'b1, 1'b1});
            e   = sb.pop_front();
            got = {dout, dvalid, dmulti};
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL multi_hot in=%b got %b/%b/%b want %b/%b/%b",
                         ins[i], dout, dvalid, dmulti, e.o, e.v, e.m);
            end
        end
    endtask

    task automatic test_all_zero();
        exp_t e;
        exp_t got;
        apply(4'b1000, '{2'b11, 1'b1, 1'b0});
        e   = sb.pop_front();
        got = {dout, dvalid, dmulti};
        compared++;
        if (got !== e) begin
            mismatched++;
            $display("FAIL zero_pre got %b/%b/%b want %b/%b/%b", dout, dvalid, dmulti, e.o, e.v, e.m);
        end
        apply(4'b0000, '{2'b00, 1'b0, 1'b0});
        e   = sb.pop_front();
        got = {dout, dvalid, dmulti};
        compared++;
        if (got !== e) begin
            mismatched++;
            $display("FAIL all_zero got %b/%b/%b want %b/%b/%b", dout, dvalid, dmulti, e.o, e.v, e.m);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] v;
        exp_t e;
        exp_t got;
        for (int i = 0; i < 8; i++) begin
            v = (i % 2 == 0) ? 4'b0001 : 4'b1000;
            apply(v, model(v));
            e   = sb.pop_front();
            got = {dout, dvalid, dmulti};
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL b2b_edge cyc=%0d got %b/%b/%b want %b/%b/%b",
                         i, dout, dvalid, dmulti, e.o, e.v, e.m);
            end
            // Change the input mid-cycle; the registered output must not move.
            din = ~v;
            #3;
            got = {dout, dvalid, dmulti};
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL b2b_stable cyc=%0d got %b/%b/%b want %b/%b/%b",
                         i, dout, dvalid, dmulti, e.o, e.v, e.m);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        exp_t got;
        apply(4'b1000, '{2'b11, 1'b1, 1'b0});
        e   = sb.pop_front();
        got = {dout, dvalid, dmulti};
        compared++;
        if (got !== e) begin
            mismatched++;
            $display("FAIL arst_pre got %b/%b/%b want %b/%b/%b", dout, dvalid, dmulti, e.o, e.v, e.m);
        end
        #2;
        rst = 1'b1;
        #1;
        got = {dout, dvalid, dmulti};
        compared++;
        if (got !== 4'b0000) begin
            mismatched++;
            $display("FAIL arst_immediate got %b/%b/%b want 00/0/0", dout, dvalid, dmulti);
        end
        din = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            got = {dout, dvalid, dmulti};
            compared++;
            if (got !== 4'b0000) begin
                mismatched++;
                $display("FAIL arst_hold clk=%0d got %b/%b/%b want 00/0/0", i, dout, dvalid, dmulti);
            end
        end
        din = 4'b0100;
        #2;
        rst = 1'b0;
        apply(4'b0100, '{2'b10, 1'b1, 1'b0});
        e   = sb.pop_front();
        got = {dout, dvalid, dmulti};
        compared++;
        if (got !== e) begin
            mismatched++;
            $display("FAIL arst_release got %b/%b/%b want %b/%b/%b", dout, dvalid, dmulti, e.o, e.v, e.m);
        end
    endtask

    task automatic test_exhaustive();
        logic [3:0] v;
        exp_t e;
        exp_t got;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            apply(v, model(v));
            e   = sb.pop_front();
            got = {dout, dvalid, dmulti};
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL exhaustive in=%b got %b/%b/%b want %b/%b/%b",
                         v, dout, dvalid, dmulti, e.o, e.v, e.m);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_one_hot();
        test_multi_hot();
        test_all_zero();
        test_back_to_back();
        test_async_reset();
        test_exhaustive();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
